// File: rtl/def_cmd_sched_if.sv
// ---------------------------------------------------------------------------
// def_cmd_sched_if
// Bundles the NIOS cmd-bus write port, both transmitter channel handshakes
// and the status outputs of def_cmd_sched.
//   master : the bus/transmitter side (drives cmd writes and sink readies)
//   slave  : the scheduler itself
// Signals:
//   i_cmd_wr / i_cmd_addr / i_cmd_data    cmd-bus write strobe, address, data
//   o_cntr_data0/1, o_cntr_valid0/1,
//   i_cntr_ready0/1                       per-channel valid/ready command stream
//   o_full, o_empty                       per-channel FIFO flags (bit n = channel n)
//   o_ovf0, o_ovf1                        per-channel dropped-command counts
//   o_busy                                any work pending anywhere
// ---------------------------------------------------------------------------
interface def_cmd_sched_if;
   logic        i_cmd_wr;
   logic [7:0]  i_cmd_addr;
   logic [31:0] i_cmd_data;
   logic [31:0] o_cntr_data0;
   logic        o_cntr_valid0;
   logic        i_cntr_ready0;
   logic [31:0] o_cntr_data1;
   logic        o_cntr_valid1;
   logic        i_cntr_ready1;
   logic [1:0]  o_full;
   logic [1:0]  o_empty;
   logic [7:0]  o_ovf0;
   logic [7:0]  o_ovf1;
   logic        o_busy;

   modport master (
      output i_cmd_wr, i_cmd_addr, i_cmd_data, i_cntr_ready0, i_cntr_ready1,
      input  o_cntr_data0, o_cntr_valid0, o_cntr_data1, o_cntr_valid1,
             o_full, o_empty, o_ovf0, o_ovf1, o_busy
   );

   modport slave (
      input  i_cmd_wr, i_cmd_addr, i_cmd_data, i_cntr_ready0, i_cntr_ready1,
      output o_cntr_data0, o_cntr_valid0, o_cntr_data1, o_cntr_valid1,
             o_full, o_empty, o_ovf0, o_ovf1, o_busy
   );
endinterface

// File: rtl/def_cmd_sched.sv
// ---------------------------------------------------------------------------
// def_cmd_sched
// Command scheduler for the two defectoscope control transmitters. Decodes
// cmd-bus writes, queues 32-bit commands per channel (unicast or broadcast)
// and feeds each channel over valid/ready with a minimum inter-command gap.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    def_cmd_sched_if.slave (cmd bus, two channel streams, status)
// ---------------------------------------------------------------------------
module def_cmd_sched #(
   parameter int         DEPTH    = 8,
   parameter int         GAP      = 4,
   parameter logic [7:0] ADDR_CH0 = 8'h10,
   parameter logic [7:0] ADDR_CH1 = 8'h11,
   parameter logic [7:0] ADDR_BC  = 8'h12,
   parameter logic [7:0] ADDR_CLR = 8'h13
) (
   input  logic           clk,
   input  logic           reset,
   def_cmd_sched_if.slave bus
);
   localparam int         AW       = $clog2(DEPTH);
   // Gap counter value on the last idle clock; unused when GAP is 0.
   localparam logic [7:0] GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   logic        clr;
   logic        bc_hit;
   logic [1:0]  ready_v;
   logic [1:0]  valid_v;
   logic [1:0]  full_v;
   logic [1:0]  empty_v;
   logic [1:0]  active_v;
   logic [31:0] data_v [2];
   logic [7:0]  ovf_v  [2];

   assign clr     = bus.i_cmd_wr && (bus.i_cmd_addr == ADDR_CLR);
   assign bc_hit  = bus.i_cmd_wr && (bus.i_cmd_addr == ADDR_BC);
   assign ready_v = {bus.i_cntr_ready1, bus.i_cntr_ready0};

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      localparam logic [7:0] ADDR_OWN = (ch == 0) ? ADDR_CH0 : ADDR_CH1;

      logic [31:0] mem [DEPTH];
      logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
      logic        full_q, empty_q;
      logic        push_req, push_ok, drop, pop;
      logic [7:0]  ovf_q, gap_cnt;
      logic [31:0] data_q;
      logic        valid;
      state_t      state, state_nxt;

      // Full is judged on the registered flag only, so a push meeting a
      // same-cycle pop on a full FIFO is still dropped.
      assign push_req   = bus.i_cmd_wr && !clr &&
                          ((bus.i_cmd_addr == ADDR_OWN) || bc_hit);
      assign push_ok    = push_req && !full_q;
      assign drop       = push_req && full_q;
      assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
      assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

      // NOTE: storage array has no reset; only pointers and flags define
      // what is valid, so the RAM can map onto plain registers or LUT-RAM.
      always_ff @(posedge clk) begin
         if (push_ok) mem[wr_ptr[AW-1:0]] <= bus.i_cmd_data;
      end

      // NOTE: all state updates use non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      always_ff @(posedge clk or posedge reset) begin
         if (reset || clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
         end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            // Extra MSB distinguishes full (MSBs differ) from empty.
            full_q  <= (wr_ptr_nxt ^ rd_ptr_nxt) == {1'b1, {AW{1'b0}}};
            empty_q <= (wr_ptr_nxt == rd_ptr_nxt);
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset || clr)                ovf_q <= 8'd0;
         else if (drop && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
      end

      // Counts idle clocks while in ST_GAP; zero on entry.
      always_ff @(posedge clk or posedge reset) begin
         if (reset || clr)          gap_cnt <= 8'd0;
         else if (state == ST_GAP)  gap_cnt <= gap_cnt + 8'd1;
         else                       gap_cnt <= 8'd0;
      end

      // Word register keeps the last word after its transfer; CLR leaves it.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)    data_q <= 32'd0;
         else if (pop) data_q <= mem[rd_ptr[AW-1:0]];
      end

      // FSM: state register
      always_ff @(posedge clk or posedge reset) begin
         if (reset) state <= ST_IDLE;
         else       state <= state_nxt;
      end

      // FSM: next state
      always_comb begin
         // NOTE: default first so every path assigns and no latch is inferred.
         state_nxt = state;
         if (clr) begin
            state_nxt = ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (!empty_q) state_nxt = ST_SEND;
               ST_SEND: begin
                  if (ready_v[ch]) begin
                     if (GAP != 0)    state_nxt = ST_GAP;
                     else if (empty_q) state_nxt = ST_IDLE;
                  end
               end
               ST_GAP: begin
                  if (gap_cnt == GAP_LAST) state_nxt = empty_q ? ST_IDLE : ST_SEND;
               end
               default: state_nxt = ST_IDLE;
            endcase
         end
      end

      // FSM: outputs (pop loads the word register on the same edge as the
      // move into ST_SEND, so data and valid appear together).
      always_comb begin
         pop   = 1'b0;
         valid = (state == ST_SEND);
         if (!clr) begin
            case (state)
               ST_IDLE: pop = !empty_q;
               ST_SEND: pop = ready_v[ch] && (GAP == 0) && !empty_q;
               ST_GAP:  pop = (gap_cnt == GAP_LAST) && !empty_q;
               default: pop = 1'b0;
            endcase
         end
      end

      assign full_v[ch]   = full_q;
      assign empty_v[ch]  = empty_q;
      assign active_v[ch] = (state != ST_IDLE);
      assign valid_v[ch]  = valid;
      assign data_v[ch]   = data_q;
      assign ovf_v[ch]    = ovf_q;
   end

   assign bus.o_cntr_data0  = data_v[0];
   assign bus.o_cntr_valid0 = valid_v[0];
   assign bus.o_cntr_data1  = data_v[1];
   assign bus.o_cntr_valid1 = valid_v[1];
   assign bus.o_full        = full_v;
   assign bus.o_empty       = empty_v;
   assign bus.o_ovf0        = ovf_v[0];
   assign bus.o_ovf1        = ovf_v[1];
   assign bus.o_busy        = (~&empty_v) || (|active_v);
endmodule
